// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg
//   Shared definitions for the hazard/stall controller slice.
//   - hazard_state_e : load-use FSM state encoding
//   - OUT_*          : 4-bit control encodings {PCWrite, IF_ID_Write, stall_mux, IF_Flush}
//   - clog2          : ceiling log2 for sizing internal countdowns
package hazard_control_unit_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } hazard_state_e;

  localparam logic [3:0] OUT_NORMAL = 4'b1110;
  localparam logic [3:0] OUT_STALL  = 4'b0000;
  localparam logic [3:0] OUT_FLUSH  = 4'b1101;
  localparam logic [3:0] OUT_RESET  = 4'b0001;

  // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// hazard_sat_counter
//   Saturating up-counter used for the stall and flush performance counters.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count this cycle
//     clear      : synchronous clear, takes priority over inc
//     count      : current value, sticks at all-ones
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  // Clear beats increment so software can zero the counter during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Hazard/stall controller between ID/EX control and the IF/PC/IF_ID registers.
//   Inputs : clk, rst_n, ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs,
//            IF_ID_RegisterRt, IF_ID_UsesMdu, EX_MduStart, PCSrc, cnt_clear
//   Outputs: PCWrite, IF_ID_Write, stall_mux, IF_Flush (pipeline control),
//            mdu_busy, stall_count, flush_count (status / performance)
//   A fresh hazard is answered combinationally in the same cycle; the registered
//   load countdown and MDU countdown carry stalls that last several cycles.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 4,
  parameter int ZERO_EXEMPT       = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_UsesMdu,
  input  logic                  EX_MduStart,
  input  logic                  PCSrc,
  input  logic                  cnt_clear,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  stall_mux,
  output logic                  IF_Flush,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // The load countdown only ever holds LOAD_STALL_CYCLES-1.
  localparam int LOAD_CNT_W = (clog2(LOAD_STALL_CYCLES) < 1) ? 1 : clog2(LOAD_STALL_CYCLES);
  localparam int MDU_CNT_W  = clog2(MDU_LATENCY + 1);

  hazard_state_e         state, state_next;
  logic [LOAD_CNT_W-1:0] load_cnt, load_cnt_next;
  logic [MDU_CNT_W-1:0]  mdu_cnt;
  logic [3:0]            ctrl;
  logic                  load_hit;
  logic                  mdu_hit;
  logic                  zero_exempt_hit;

  // A load writing $zero produces nothing a consumer could wait for.
  assign zero_exempt_hit = (ZERO_EXEMPT != 0) && (ID_EX_RegisterRt == '0);
  assign load_hit = ID_EX_MemRead && !zero_exempt_hit &&
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                     (ID_EX_RegisterRt == IF_ID_RegisterRt));
  assign mdu_busy = (mdu_cnt != '0);
  assign mdu_hit  = IF_ID_UsesMdu && mdu_busy;

  // Load-use FSM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      load_cnt <= '0;
    end else begin
      state    <= state_next;
      load_cnt <= load_cnt_next;
    end
  end

  // Priority: redirect flush, then load stall, then MDU interlock, else run.
  // A redirect aborts any load stall because the stalled instruction is wrong-path.
  always_comb begin
    state_next    = state;
    load_cnt_next = load_cnt;
    ctrl          = OUT_NORMAL;
    if (PCSrc) begin
      ctrl          = OUT_FLUSH;
      state_next    = IDLE;
      load_cnt_next = '0;
    end else if (state == LOAD_STALL) begin
      ctrl          = OUT_STALL;
      load_cnt_next = load_cnt - LOAD_CNT_W'(1);
      if (load_cnt == LOAD_CNT_W'(1)) begin
        state_next = IDLE;
      end
    end else if (load_hit) begin
      ctrl = OUT_STALL;
      if (LOAD_STALL_CYCLES > 1) begin
        state_next    = LOAD_STALL;
        load_cnt_next = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);
      end
    end else if (mdu_hit) begin
      ctrl = OUT_STALL;
    end
    if (!rst_n) begin
      ctrl = OUT_RESET;
    end
  end

  assign {PCWrite, IF_ID_Write, stall_mux, IF_Flush} = ctrl;

  // MDU countdown: a start (even under a redirect, the EX op is committed)
  // reloads the full latency, otherwise count down to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else if (EX_MduStart) begin
      mdu_cnt <= MDU_CNT_W'(MDU_LATENCY);
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!PCWrite),
    .clear (cnt_clear),
    .count (stall_count)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_Flush),
    .clear (cnt_clear),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Directed bench for hazard_control_unit. Two instances share every input:
//   dut_a (3-cycle load stall, $zero exempt) and dut_b (1-cycle load stall,
//   no $zero exemption); both use 4-bit counters and a 4-cycle MDU.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       uses_mdu;
  logic       mdu_start;
  logic       pc_src;
  logic       cnt_clear;

  logic       a_pc_write, a_ifid_write, a_stall_mux, a_if_flush, a_mdu_busy;
  logic [3:0] a_stall_count, a_flush_count;
  logic       b_pc_write, b_ifid_write, b_stall_mux, b_if_flush, b_mdu_busy;
  logic [3:0] b_stall_count, b_flush_count;
  logic [3:0] a_ctrl, b_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  assign a_ctrl = {a_pc_write, a_ifid_write, a_stall_mux, a_if_flush};
  assign b_ctrl = {b_pc_write, b_ifid_write, b_stall_mux, b_if_flush};

  hazard_control_unit #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .MDU_LATENCY(4), .ZERO_EXEMPT(1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt),
    .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
    .IF_ID_UsesMdu(uses_mdu), .EX_MduStart(mdu_start),
    .PCSrc(pc_src), .cnt_clear(cnt_clear),
    .PCWrite(a_pc_write), .IF_ID_Write(a_ifid_write),
    .stall_mux(a_stall_mux), .IF_Flush(a_if_flush),
    .mdu_busy(a_mdu_busy), .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  hazard_control_unit #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .MDU_LATENCY(4), .ZERO_EXEMPT(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt),
    .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
    .IF_ID_UsesMdu(uses_mdu), .EX_MduStart(mdu_start),
    .PCSrc(pc_src), .cnt_clear(cnt_clear),
    .PCWrite(b_pc_write), .IF_ID_Write(b_ifid_write),
    .stall_mux(b_stall_mux), .IF_Flush(b_if_flush),
    .mdu_busy(b_mdu_busy), .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  // 10-unit clock; inputs change 1 unit after the rising edge, outputs are sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks = n_checks + 1;
    if (observed === expected) begin
      n_pass = n_pass + 1;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic um, input logic ms,
                               input logic pcs, input logic clr);
    mem_read  = mr;
    ex_rt     = ert;
    id_rs     = rs;
    id_rt     = rt;
    uses_mdu  = um;
    mdu_start = ms;
    pc_src    = pcs;
    cnt_clear = clr;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations for the MDU windows after the start edge.
  logic [3:0] mdu_out_exp  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1110};
  logic       mdu_busy_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_ctrl_a", 16'(a_ctrl), 16'h0001);
    checkOutput("reset_stall_cnt_a", 16'(a_stall_count), 16'h0);
    checkOutput("reset_busy_a", 16'(a_mdu_busy), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ctrl_a", 16'(a_ctrl), 16'hE);
    checkOutput("idle_ctrl_b", 16'(b_ctrl), 16'hE);
    advance();

    // Load-use on Rs: dut_a stalls 3 cycles, dut_b stalls 1.
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("load_c0_a", 16'(a_ctrl), 16'h0);
    checkOutput("load_c0_b", 16'(b_ctrl), 16'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("load_c1_a", 16'(a_ctrl), 16'h0);
    checkOutput("load_c1_b", 16'(b_ctrl), 16'hE);
    advance();
    @(negedge clk);
    checkOutput("load_c2_a", 16'(a_ctrl), 16'h0);
    advance();
    @(negedge clk);
    checkOutput("load_c3_a", 16'(a_ctrl), 16'hE);
    checkOutput("load_stall_cnt_a", 16'(a_stall_count), 16'd3);
    checkOutput("load_stall_cnt_b", 16'(b_stall_count), 16'd1);
    advance();

    // $zero destination: exempt in dut_a, a real hazard in dut_b.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("zero_a", 16'(a_ctrl), 16'hE);
    checkOutput("zero_b", 16'(b_ctrl), 16'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("zero_after_b", 16'(b_ctrl), 16'hE);
    checkOutput("zero_stall_cnt_b", 16'(b_stall_count), 16'd2);
    advance();

    // Counter clear.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clear_stall_cnt_a", 16'(a_stall_count), 16'd0);
    checkOutput("clear_stall_cnt_b", 16'(b_stall_count), 16'd0);
    advance();

    // Load-use on Rt, then a redirect in the second stall cycle aborts it.
    applyStimulus(1, 5, 3, 5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("branch_c0_a", 16'(a_ctrl), 16'h0);
    checkOutput("branch_c0_b", 16'(b_ctrl), 16'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("branch_c1_a", 16'(a_ctrl), 16'hD);
    checkOutput("branch_c1_b", 16'(b_ctrl), 16'hD);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("branch_c2_a", 16'(a_ctrl), 16'hE);
    checkOutput("branch_stall_cnt_a", 16'(a_stall_count), 16'd1);
    checkOutput("branch_flush_cnt_a", 16'(a_flush_count), 16'd1);
    checkOutput("branch_flush_cnt_b", 16'(b_flush_count), 16'd1);
    advance();

    // MDU interlock: start pulse, then a consumer held in ID.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("mdu_start_ctrl_a", 16'(a_ctrl), 16'hE);
    checkOutput("mdu_start_busy_a", 16'(a_mdu_busy), 16'h0);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mdu_ctrl_%0d", i), 16'(a_ctrl), 16'(mdu_out_exp[i]));
      checkOutput($sformatf("mdu_busy_%0d", i), 16'(a_mdu_busy), 16'(mdu_busy_exp[i]));
      advance();
    end

    // Restart while busy with two cycles left: four fresh busy cycles follow.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    advance();
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("mdu_restart_pre_busy", 16'(a_mdu_busy), 16'h1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mdu_restart_busy_%0d", i), 16'(a_mdu_busy), 16'(mdu_busy_exp[i]));
      advance();
    end

    // Saturation: clear, then 20 back-to-back stall cycles on a 4-bit counter.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    advance();
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      advance();
    end
    @(negedge clk);
    checkOutput("sat_ctrl_a", 16'(a_ctrl), 16'h0);
    checkOutput("sat_stall_cnt_a", 16'(a_stall_count), 16'd15);
    checkOutput("sat_stall_cnt_b", 16'(b_stall_count), 16'd15);
    advance();
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 1);
    advance();
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("sat_clear_cnt_a", 16'(a_stall_count), 16'd0);
    advance();
    @(negedge clk);
    checkOutput("sat_resume_cnt_a", 16'(a_stall_count), 16'd1);
    advance();

    // Asynchronous reset in the middle of a load stall.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    advance();
    advance();
    applyStimulus(1, 8, 8, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pre_reset_ctrl_a", 16'(a_ctrl), 16'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midstall_reset_ctrl_a", 16'(a_ctrl), 16'h1);
    checkOutput("midstall_reset_stall_cnt_a", 16'(a_stall_count), 16'd0);
    checkOutput("midstall_reset_flush_cnt_a", 16'(a_flush_count), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ctrl_a", 16'(a_ctrl), 16'hE);
    checkOutput("post_reset_ctrl_b", 16'(b_ctrl), 16'hE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
